// File: rtl/mc_result_uart_tx.sv
// mc_result_uart_tx
// Waits for a rising edge on the estimator's finish flag. On that edge it
// snapshots pi_yes, pi_no and rng_exhaust. It then sends one fixed 11-byte
// frame on an 8N1 UART line:
//   A5, {7'b0,rng_exhaust}, pi_yes[31:0] MSB byte first,
//   pi_no[31:0] MSB byte first, XOR of the ten preceding bytes.
// Each byte goes out LSB first, and every bit lasts CLKS_PER_BIT cycles.
//
// Trigger semantics (there is no valid/ready handshake here): the trigger
// is finish & ~finish_q. It is acted on only while the FSM is idle. A
// trigger that arrives while busy is dropped, not queued. busy is high from
// the edge after the trigger up to and including the final stop bit. done
// pulses for one cycle on the edge where busy falls.
module mc_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finish,
  input  logic [31:0] pi_yes,
  input  logic [31:0] pi_no,
  input  logic        rng_exhaust,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BYTE = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [3:0]    byte_idx, byte_n;
  logic [31:0]   snap_yes, snap_no;
  logic          snap_exh;
  logic          finish_q;
  logic          tx_n, busy_n, done_n, load_snap;
  logic          trigger;
  logic          baud_last;
  logic [2:0]    bit_nxt;
  logic [7:0]    cur_byte;
  logic [7:0]    checksum;

  assign trigger   = finish & ~finish_q;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign bit_nxt   = bit_idx + 3'd1;

  // The checksum is formed directly from the snapshot. It is therefore
  // stable for the whole frame and needs no accumulator.
  assign checksum = 8'hA5 ^ {7'b0, snap_exh}
                  ^ snap_yes[31:24] ^ snap_yes[23:16] ^ snap_yes[15:8] ^ snap_yes[7:0]
                  ^ snap_no[31:24]  ^ snap_no[23:16]  ^ snap_no[15:8]  ^ snap_no[7:0];

  // Select the byte currently on the line from the snapshot and byte index.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      4'd0:    cur_byte = 8'hA5;
      4'd1:    cur_byte = {7'b0, snap_exh};
      4'd2:    cur_byte = snap_yes[31:24];
      4'd3:    cur_byte = snap_yes[23:16];
      4'd4:    cur_byte = snap_yes[15:8];
      4'd5:    cur_byte = snap_yes[7:0];
      4'd6:    cur_byte = snap_no[31:24];
      4'd7:    cur_byte = snap_no[23:16];
      4'd8:    cur_byte = snap_no[15:8];
      4'd9:    cur_byte = snap_no[7:0];
      4'd10:   cur_byte = checksum;
      default: cur_byte = 8'h00;
    endcase
  end

  // Next-state and next-output logic. tx is computed for the state being
  // entered, so that the registered line changes on the same edge as the
  // state.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    tx_n      = tx;
    busy_n    = busy;
    done_n    = 1'b0;
    load_snap = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (trigger) begin
          load_snap = 1'b1;
          state_n   = ST_START;
          baud_n    = '0;
          bit_n     = 3'd0;
          byte_n    = 4'd0;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = ST_DATA;
          tx_n    = cur_byte[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_nxt;
            tx_n  = cur_byte[bit_nxt];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (byte_idx == LAST_BYTE) begin
            state_n = ST_IDLE;
            byte_n  = 4'd0;
            bit_n   = 3'd0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            byte_n  = byte_idx + 4'd1;
            state_n = ST_START;
            tx_n    = 1'b0;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counters, registered outputs and the edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
      finish_q <= finish;
    end
  end

  // The snapshot is loaded only on an accepted trigger. Input changes
  // during a frame therefore never reach the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_yes <= 32'd0;
      snap_no  <= 32'd0;
      snap_exh <= 1'b0;
    end else if (load_snap) begin
      snap_yes <= pi_yes;
      snap_no  <= pi_no;
      snap_exh <= rng_exhaust;
    end
  end

endmodule

// File: tb/tb_mc_result_uart_tx.sv
// Bench for mc_result_uart_tx, run with CLKS_PER_BIT = 4.
// Frames are predicted from the byte layout and 8N1 framing rules. The
// UART line is compared cycle by cycle, and each byte is also decoded from
// mid-bit samples.
module tb_mc_result_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        finish;
  logic [31:0] pi_yes;
  logic [31:0] pi_no;
  logic        rng_exhaust;
  logic        tx;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  mc_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .finish      (finish),
    .pi_yes      (pi_yes),
    .pi_no       (pi_no),
    .rng_exhaust (rng_exhaust),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: push the 11 expected frame bytes.
  task automatic model_frame(input logic [31:0] y, input logic [31:0] n, input logic e);
    logic [7:0] b[11];
    logic [7:0] x;
    b[0] = 8'hA5;
    b[1] = {7'b0, e};
    for (int i = 0; i < 4; i++) begin
      b[2 + i] = y[31 - 8*i -: 8];
      b[6 + i] = n[31 - 8*i -: 8];
    end
    x = 8'h00;
    for (int i = 0; i < 10; i++) x = x ^ b[i];
    b[10] = x;
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
  endtask

  // Called at the negedge just before the trigger edge. Checks every cycle
  // of the frame and the cycle in which busy falls.
  task automatic check_frame();
    logic [7:0] eb;
    logic [7:0] got;
    logic       eb_bit;
    for (int k = 0; k < 11; k++) begin
      eb  = exp_q.pop_front();
      got = 8'h00;
      for (int p = 0; p < 10; p++) begin
        eb_bit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : eb[p-1];
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          check("tx_bit", tx, eb_bit);
          check("busy_in_frame", busy, 1);
          check("done_in_frame", done, 0);
          if (p >= 1 && p <= 8 && c == CPB/2) got[p-1] = tx;
        end
      end
      check("byte", got, eb);
    end
    @(negedge clk);
    check("busy_end", busy, 0);
    check("done_pulse", done, 1);
    check("tx_idle_end", tx, 1);
  endtask

  // Driver: raise finish with new data at a negedge, check the frame,
  // and drop finish partway through the frame.
  task automatic run_frame(input logic [31:0] y, input logic [31:0] n, input logic e);
    pi_yes      = y;
    pi_no       = n;
    rng_exhaust = e;
    finish      = 1'b1;
    model_frame(y, n, e);
    fork
      check_frame();
      begin
        repeat (8) @(negedge clk);
        finish = 1'b0;
      end
    join
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_tx"}, tx, 1);
      check({tag, "_done"}, done, 0);
    end
  endtask

  initial begin
    // reset
    rst         = 1'b1;
    finish      = 1'b0;
    pi_yes      = 32'd0;
    pi_no       = 32'd0;
    rng_exhaust = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle(4, "post_rst");

    // known vector from the plan
    run_frame(32'h0000030E, 32'h000000D9, 1'b0);
    check_idle(5, "idle1");

    // all-ones pi_yes with exhaust set
    run_frame(32'hFFFFFFFF, 32'h12345678, 1'b1);
    check_idle(5, "idle2");

    // inputs change and finish re-rises mid-frame: snapshot kept, no retrigger
    pi_yes      = 32'hCAFEF00D;
    pi_no       = 32'h0BADBEEF;
    rng_exhaust = 1'b0;
    finish      = 1'b1;
    model_frame(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
    fork
      check_frame();
      begin
        repeat (100) @(negedge clk);
        pi_yes      = $urandom;
        pi_no       = $urandom;
        rng_exhaust = 1'b1;
        finish      = 1'b0;
        repeat (20) @(negedge clk);
        finish = 1'b1;
      end
    join
    check_idle(40, "no_retrig");
    finish = 1'b0;
    @(negedge clk);

    // reset during byte 4 data bits
    pi_yes      = 32'h89ABCDEF;
    pi_no       = 32'h01234567;
    rng_exhaust = 1'b1;
    finish      = 1'b1;
    repeat (4*10*CPB + 2*CPB + 1) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    finish = 1'b0;
    check_idle(3, "in_rst");
    rst = 1'b0;
    check_idle(4, "after_rst");
    run_frame(32'h89ABCDEF, 32'h01234567, 1'b1);
    check_idle(3, "idle3");

    // finish held high through reset release: exactly one frame
    rst         = 1'b1;
    finish      = 1'b1;
    pi_yes      = 32'h00C0FFEE;
    pi_no       = 32'h00000042;
    rng_exhaust = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_frame(32'h00C0FFEE, 32'h00000042, 1'b0);
    check_frame();
    check_idle(30, "held_high");
    finish = 1'b0;
    @(negedge clk);
    run_frame(32'h11112222, 32'h33334444, 1'b1);

    // random frames, back to back: each trigger lands on the first idle cycle
    for (int i = 0; i < 4; i++) begin
      run_frame($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    check_idle(5, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
